// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard between ID and EX: one countdown per register tracks
// in-flight writes and drives stall plus per-operand forwarding selects.
module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int LAT_MAX = 4,
    parameter int WB_DLY  = 2,
    parameter int FWD_EN  = 1,
    localparam int NUM_REGS = 2 ** REG_AW,
    localparam int LAT_W    = $clog2(LAT_MAX + 1),
    localparam int CNT_W    = $clog2(LAT_MAX + WB_DLY),
    localparam int SEL_W    = $clog2(WB_DLY + 1)
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                en,
    input  logic                issue_valid,
    input  logic                flush,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic                rs1_used,
    input  logic [REG_AW-1:0]   rs2_addr,
    input  logic                rs2_used,
    input  logic [REG_AW-1:0]   rd_addr,
    input  logic                rd_we,
    input  logic [LAT_W-1:0]    rd_lat,
    output logic                stall,
    output logic [SEL_W-1:0]    fwd_sel_1,
    output logic [SEL_W-1:0]    fwd_sel_2,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [CNT_W-1:0] WB_CNT = CNT_W'(WB_DLY);
    localparam logic [LAT_W-1:0] LAT_LIM = LAT_W'(LAT_MAX);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] lat_eff;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt_rs1;
    logic [CNT_W-1:0] cnt_rs2;
    logic [CNT_W-1:0] cnt_rd;
    logic             fwd_ok_1;
    logic             fwd_ok_2;
    logic             ready_1;
    logic             ready_2;
    logic             raw;
    logic             waw;
    logic             issue;

    // Out-of-range latencies are clamped so the countdown load always fits the counter.
    always_comb begin
        lat_eff = rd_lat;
        if (rd_lat == '0) begin
            lat_eff = LAT_W'(1);
        end else if (rd_lat > LAT_LIM) begin
            lat_eff = LAT_LIM;
        end
        load_val = CNT_W'(lat_eff) + CNT_W'(WB_DLY - 1);
    end

    assign cnt_rs1 = cnt[rs1_addr];
    assign cnt_rs2 = cnt[rs2_addr];
    assign cnt_rd  = cnt[rd_addr];

    assign fwd_ok_1 = (FWD_EN != 0) && rs1_used && (rs1_addr != '0) && (cnt_rs1 <= WB_CNT);
    assign fwd_ok_2 = (FWD_EN != 0) && rs2_used && (rs2_addr != '0) && (cnt_rs2 <= WB_CNT);

    assign ready_1 = !rs1_used || (rs1_addr == '0) || (cnt_rs1 == '0) || fwd_ok_1;
    assign ready_2 = !rs2_used || (rs2_addr == '0) || (cnt_rs2 == '0) || fwd_ok_2;

    // A younger writer with a shorter latency must wait so writebacks retire in order.
    assign raw   = issue_valid && (!ready_1 || !ready_2);
    assign waw   = issue_valid && rd_we && (rd_addr != '0) && (cnt_rd > load_val);
    assign stall = (raw || waw) && !flush;
    assign issue = issue_valid && en && !flush && !stall;

    assign fwd_sel_1 = fwd_ok_1 ? SEL_W'(cnt_rs1) : '0;
    assign fwd_sel_2 = fwd_ok_2 ? SEL_W'(cnt_rs2) : '0;

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    // Entry 0 is never loaded, so x0 stays permanently ready after reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (srst) begin
                cnt[r] <= '0;
            end else if (en) begin
                if ((r != 0) && issue && rd_we && (rd_addr == REG_AW'(r))) begin
                    cnt[r] <= load_val;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a forwarding instance and a no-forwarding
// instance share stimulus; expected outputs travel through a queue to the check point.
module tb_hazard_scoreboard;

    typedef struct {
        logic        srst;
        logic        en;
        logic        iv;
        logic        fl;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  lat;
        logic        chk;
        logic        dut;
        logic        exp_stall;
        logic [1:0]  exp_s1;
        logic [1:0]  exp_s2;
        logic [31:0] exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        srst, en, issue_valid, flush;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rs1_used, rs2_used, rd_we;
    logic [2:0]  rd_lat;
    logic        stall, nf_stall;
    logic [1:0]  fwd_sel_1, fwd_sel_2, nf_sel_1, nf_sel_2;
    logic [31:0] busy_vec, nf_busy;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   vec_idx = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .LAT_MAX(4), .WB_DLY(2), .FWD_EN(1)) dut (
        .clk(clk), .srst(srst), .en(en), .issue_valid(issue_valid), .flush(flush),
        .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
        .rd_addr(rd_addr), .rd_we(rd_we), .rd_lat(rd_lat),
        .stall(stall), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2), .busy_vec(busy_vec)
    );

    hazard_scoreboard #(.REG_AW(5), .LAT_MAX(4), .WB_DLY(2), .FWD_EN(0)) dut_nf (
        .clk(clk), .srst(srst), .en(en), .issue_valid(issue_valid), .flush(flush),
        .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs2_addr(rs2_addr), .rs2_used(rs2_used),
        .rd_addr(rd_addr), .rd_we(rd_we), .rd_lat(rd_lat),
        .stall(nf_stall), .fwd_sel_1(nf_sel_1), .fwd_sel_2(nf_sel_2), .busy_vec(nf_busy)
    );

    function automatic vec_t mk(input int s, input int e, input int iv, input int fl,
                                input int rs1, input int u1, input int rs2, input int u2,
                                input int rd, input int we, input int lat, input int chk,
                                input int d, input int st, input int s1, input int s2,
                                input logic [31:0] busy);
        vec_t v;
        v.srst = 1'(s);   v.en = 1'(e);    v.iv = 1'(iv);   v.fl = 1'(fl);
        v.rs1 = 5'(rs1);  v.u1 = 1'(u1);   v.rs2 = 5'(rs2); v.u2 = 1'(u2);
        v.rd = 5'(rd);    v.we = 1'(we);   v.lat = 3'(lat);
        v.chk = 1'(chk);  v.dut = 1'(d);   v.exp_stall = 1'(st);
        v.exp_s1 = 2'(s1); v.exp_s2 = 2'(s2); v.exp_busy = busy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        srst = v.srst; en = v.en; issue_valid = v.iv; flush = v.fl;
        rs1_addr = v.rs1; rs1_used = v.u1; rs2_addr = v.rs2; rs2_used = v.u2;
        rd_addr = v.rd; rd_we = v.we; rd_lat = v.lat;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t        e;
        logic        got_st;
        logic [1:0]  got_s1, got_s2;
        logic [31:0] got_busy;
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.chk) begin
            got_st   = e.dut ? nf_stall : stall;
            got_s1   = e.dut ? nf_sel_1 : fwd_sel_1;
            got_s2   = e.dut ? nf_sel_2 : fwd_sel_2;
            got_busy = e.dut ? nf_busy  : busy_vec;
            n_vec++;
            if (got_st !== e.exp_stall || got_s1 !== e.exp_s1 ||
                got_s2 !== e.exp_s2 || got_busy !== e.exp_busy) begin
                n_fail++;
                $display("[TB] FAIL vec%0d dut%0d: got stall=%b sel1=%0d sel2=%0d busy=%h, want stall=%b sel1=%0d sel2=%0d busy=%h",
                         vec_idx, e.dut, got_st, got_s1, got_s2, got_busy,
                         e.exp_stall, e.exp_s1, e.exp_s2, e.exp_busy);
            end
        end
        vec_idx++;
    endtask

    initial begin
        int stall_cycles;
        bit released;

        //               s  e iv fl rs1 u1 rs2 u2 rd we lat chk d st s1 s2 busy
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        // ALU producer x5 then three consumers
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  5, 1, 1, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0,  5, 1,  0, 0,  0, 0, 1, 1, 0, 0, 2, 0, 32'h20));
        vecs.push_back(mk(0, 1, 1, 0,  5, 1,  0, 0,  0, 0, 1, 1, 0, 0, 1, 0, 32'h20));
        vecs.push_back(mk(0, 1, 1, 0,  5, 1,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 32'h0));
        // Load x6, consumer on rs2 stalls once
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  6, 1, 2, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  6, 1,  0, 0, 1, 1, 0, 1, 0, 0, 32'h40));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  6, 1,  0, 0, 1, 1, 0, 0, 0, 2, 32'h40));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 32'h40));
        // WAW on x8: long writer then short writer
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  8, 1, 4, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  8, 1, 1, 1, 0, 1, 0, 0, 32'h100));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  8, 1, 1, 1, 0, 1, 0, 0, 32'h100));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  8, 1, 1, 1, 0, 1, 0, 0, 32'h100));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  8, 1, 1, 1, 0, 0, 0, 0, 32'h100));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 32'h100));
        // x0 as destination and source
        vecs.push_back(mk(0, 1, 1, 0,  0, 1,  0, 1,  0, 1, 4, 1, 0, 0, 0, 0, 32'h100));
        vecs.push_back(mk(0, 1, 1, 0,  0, 1,  8, 1,  0, 0, 1, 1, 0, 0, 0, 0, 32'h0));
        // Flush a hazarding writer of x10
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  9, 1, 2, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1,  9, 1,  0, 0, 10, 1, 4, 1, 0, 0, 0, 0, 32'h200));
        vecs.push_back(mk(0, 1, 0, 0,  9, 1,  0, 0,  0, 0, 1, 1, 0, 0, 2, 0, 32'h200));
        // en low for three cycles
        vecs.push_back(mk(0, 0, 1, 0,  9, 1,  0, 0, 11, 1, 4, 1, 0, 0, 1, 0, 32'h200));
        vecs.push_back(mk(0, 0, 1, 0,  9, 1,  0, 0, 11, 1, 4, 1, 0, 0, 1, 0, 32'h200));
        vecs.push_back(mk(0, 0, 1, 0,  9, 1,  0, 0, 11, 1, 4, 1, 0, 0, 1, 0, 32'h200));
        vecs.push_back(mk(0, 1, 0, 0,  9, 1,  0, 0, 11, 0, 4, 1, 0, 0, 1, 0, 32'h200));
        vecs.push_back(mk(0, 1, 0, 0,  9, 1,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 32'h0));
        // en low while stalled on a load of x12
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0, 12, 1, 2, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 12, 1,  0, 0,  0, 0, 1, 1, 0, 1, 0, 0, 32'h1000));
        vecs.push_back(mk(0, 0, 1, 0, 12, 1,  0, 0,  0, 0, 1, 1, 0, 1, 0, 0, 32'h1000));
        vecs.push_back(mk(0, 1, 1, 0, 12, 1,  0, 0,  0, 0, 1, 1, 0, 1, 0, 0, 32'h1000));
        vecs.push_back(mk(0, 1, 1, 0, 12, 1,  0, 0,  0, 0, 1, 1, 0, 0, 2, 0, 32'h1000));
        // Latency clamping: rd_lat 7 acts as 4, rd_lat 0 acts as 1
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0, 13, 1, 7, 1, 0, 0, 0, 0, 32'h1000));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0, 13, 1, 3, 1, 0, 1, 0, 0, 32'h2000));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0, 13, 1, 3, 1, 0, 0, 0, 0, 32'h2000));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0, 14, 1, 0, 1, 0, 0, 0, 0, 32'h2000));
        vecs.push_back(mk(0, 1, 1, 0, 14, 1, 13, 1,  0, 0, 1, 1, 0, 1, 2, 0, 32'h6000));
        vecs.push_back(mk(0, 1, 1, 0, 14, 1, 13, 1,  0, 0, 1, 1, 0, 0, 1, 2, 32'h6000));
        // srst mid-countdown with en low, must not load x15
        vecs.push_back(mk(1, 0, 1, 0, 13, 1,  0, 0, 15, 1, 4, 1, 0, 0, 1, 0, 32'h2000));
        vecs.push_back(mk(0, 1, 0, 0, 13, 1,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 32'h0));
        // No-forwarding instance: ALU producer x7 costs two stalls
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  7, 1, 1, 1, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0,  7, 1,  0, 0,  0, 0, 1, 1, 1, 1, 0, 0, 32'h80));
        vecs.push_back(mk(0, 1, 1, 0,  7, 1,  0, 0,  0, 0, 1, 1, 1, 1, 0, 0, 32'h80));
        vecs.push_back(mk(0, 1, 1, 0,  7, 1,  0, 0,  0, 0, 1, 1, 1, 0, 0, 0, 32'h0));

        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Long writer of x8 then a short writer held until the WAW stall releases
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        checkOutput();
        applyStimulus(mk(0, 1, 1, 0, 0, 0, 0, 0, 8, 1, 4, 1, 0, 0, 0, 0, 32'h0));
        checkOutput();
        stall_cycles = 0;
        released = 1'b0;
        for (int c = 0; c < 10 && !released; c++) begin
            @(posedge clk);
            #1;
            drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 32'h0));
            @(negedge clk);
            if (stall) stall_cycles++;
            else released = 1'b1;
        end
        n_vec++;
        if (!released || stall_cycles != 3) begin
            n_fail++;
            $display("[TB] FAIL waw_stall_len: got %0d stall cycles (released=%0b), want 3",
                     stall_cycles, released);
        end
        applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h100));
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
